// File: rtl/sp_multicycle_if.sv
// -----------------------------------------------------------------------------
// sp_multicycle_if
// Purpose : Groups the instruction handshake and data-memory bus of the
//           sp_multicycle core into one bundle.
// Signals : in_valid  - instruction valid, one-cycle pulse (producer -> core)
//           inst      - instruction word, meaningful only with in_valid
//           out_valid - one-cycle retirement pulse (core -> producer)
//           inst_addr - byte address of the next instruction to fetch
//           mem_addr  - data-memory word address
//           mem_wen   - data-memory write enable, active high
//           mem_wdata - data-memory write data
//           mem_rdata - data-memory read data, one cycle after mem_addr
// Handshake: the producer raises in_valid for exactly one cycle while the core
//           is idle; the core takes inst on that rising edge and ignores
//           in_valid until it retires the instruction with a single-cycle
//           out_valid pulse. There is no back-pressure signal: the producer
//           must wait for out_valid before issuing the next instruction.
// Modports: master - instruction source / memory model side
//           slave  - the core
// -----------------------------------------------------------------------------
interface sp_multicycle_if #(
  parameter int MEM_AW = 12
);
  logic              in_valid;
  logic [31:0]       inst;
  logic              out_valid;
  logic [31:0]       inst_addr;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_wen;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output in_valid, inst, mem_rdata,
    input  out_valid, inst_addr, mem_addr, mem_wen, mem_wdata
  );

  modport slave (
    input  in_valid, inst, mem_rdata,
    output out_valid, inst_addr, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/sp_multicycle.sv
// -----------------------------------------------------------------------------
// sp_multicycle
// Purpose : Small multicycle MIPS-like core. One instruction at a time walks
//           IDLE -> EXEC -> (MEMRD for lw) -> DONE -> IDLE. Register file and
//           pc are updated on the edge entering DONE so they are stable while
//           out_valid is high.
// Ports   : clk         - system clock, rising edge
//           rst         - asynchronous active-high reset
//           bus         - sp_multicycle_if.slave (instruction + memory bus)
//           dbg_state_o - current FSM state (0 IDLE, 1 EXEC, 2 MEMRD, 3 DONE)
// -----------------------------------------------------------------------------
module sp_multicycle #(
  parameter int MEM_AW = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  sp_multicycle_if.slave       bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_MEMRD = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ANDI  = 6'd1;
  localparam logic [5:0] OP_ORI   = 6'd2;
  localparam logic [5:0] OP_ADDI  = 6'd3;
  localparam logic [5:0] OP_SUBI  = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd6;
  localparam logic [5:0] OP_BEQ   = 6'd7;
  localparam logic [5:0] OP_BNE   = 6'd8;
  localparam logic [5:0] OP_LUI   = 6'd9;
  localparam logic [5:0] OP_J     = 6'd10;
  localparam logic [5:0] OP_JAL   = 6'd11;

  localparam logic [5:0] FN_AND = 6'd0;
  localparam logic [5:0] FN_OR  = 6'd1;
  localparam logic [5:0] FN_ADD = 6'd2;
  localparam logic [5:0] FN_SUB = 6'd3;
  localparam logic [5:0] FN_SLT = 6'd4;
  localparam logic [5:0] FN_SLL = 6'd5;
  localparam logic [5:0] FN_NOR = 6'd6;
  localparam logic [5:0] FN_JR  = 6'd7;

  state_t      state_q, state_d;
  logic [31:0] inst_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Field decode of the latched instruction
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] jaddr;

  assign opcode = inst_q[31:26];
  assign rs     = inst_q[25:21];
  assign rt     = inst_q[20:16];
  assign rd     = inst_q[15:11];
  assign shamt  = inst_q[10:6];
  assign func   = inst_q[5:0];
  assign imm    = inst_q[15:0];
  assign jaddr  = inst_q[25:0];

  logic [31:0] rs_val, rt_val, sext_imm, zext_imm, pc_plus4, br_tgt, jmp_tgt;
  logic [MEM_AW-1:0] mem_ea;
  logic              is_mem;

  assign rs_val   = rf_q[rs];
  assign rt_val   = rf_q[rt];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {sext_imm[29:0], 2'b00};
  assign jmp_tgt  = {pc_q[31:28], jaddr, 2'b00};
  // Only the low MEM_AW bits of the word address survive, so add at that width.
  assign mem_ea   = rs_val[MEM_AW-1:0] + sext_imm[MEM_AW-1:0];
  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);

  // ---------------------------------------------------------------------------
  // Next state, register write and next pc
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) state_d = S_EXEC;
      end

      S_EXEC: begin
        if (opcode == OP_LW) begin
          // Write-back and pc move wait for the read data in MEMRD.
          state_d = S_MEMRD;
        end else begin
          state_d = S_DONE;
          pc_d    = pc_plus4;
          case (opcode)
            OP_RTYPE: begin
              rf_waddr = rd;
              rf_we    = 1'b1;
              case (func)
                FN_AND: rf_wdata = rs_val & rt_val;
                FN_OR:  rf_wdata = rs_val | rt_val;
                FN_ADD: rf_wdata = rs_val + rt_val;
                FN_SUB: rf_wdata = rs_val - rt_val;
                FN_SLT: rf_wdata = {31'd0, $signed(rs_val) < $signed(rt_val)};
                FN_SLL: rf_wdata = rs_val << shamt;
                FN_NOR: rf_wdata = ~(rs_val | rt_val);
                FN_JR: begin
                  rf_we = 1'b0;
                  pc_d  = rs_val;
                end
                default: rf_we = 1'b0;
              endcase
            end
            OP_ANDI: begin rf_we = 1'b1; rf_wdata = rs_val & zext_imm; end
            OP_ORI:  begin rf_we = 1'b1; rf_wdata = rs_val | zext_imm; end
            OP_ADDI: begin rf_we = 1'b1; rf_wdata = rs_val + sext_imm; end
            OP_SUBI: begin rf_we = 1'b1; rf_wdata = rs_val - sext_imm; end
            OP_LUI:  begin rf_we = 1'b1; rf_wdata = {imm, 16'h0000}; end
            OP_BEQ:  if (rs_val == rt_val) pc_d = br_tgt;
            OP_BNE:  if (rs_val != rt_val) pc_d = br_tgt;
            OP_J:    pc_d = jmp_tgt;
            OP_JAL: begin
              rf_we    = 1'b1;
              rf_waddr = 5'd31;
              rf_wdata = pc_plus4;
              pc_d     = jmp_tgt;
            end
            default: ;  // sw and undefined opcodes: no register write
          endcase
        end
      end

      S_MEMRD: begin
        state_d  = S_DONE;
        pc_d     = pc_plus4;
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = bus.mem_rdata;
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, instruction latch, pc and register file
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      inst_q  <= 32'd0;
      pc_q    <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_IDLE && bus.in_valid) inst_q <= bus.inst;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from state_q, so reset clears them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.out_valid = (state_q == S_DONE);
    bus.inst_addr = pc_q;
    bus.mem_wen   = (state_q == S_EXEC) && (opcode == OP_SW);
    // Address is held through MEMRD so the read stays pointed at the same word.
    bus.mem_addr  = ((state_q == S_EXEC || state_q == S_MEMRD) && is_mem) ? mem_ea : '0;
    bus.mem_wdata = bus.mem_wen ? rt_val : 32'd0;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sp_multicycle.sv
// -----------------------------------------------------------------------------
// tb_sp_multicycle
// Directed bench for sp_multicycle. Register contents are observed through the
// memory bus: a store of the register under test is issued and the expected
// {address, data} is queued in the write scoreboard.
// -----------------------------------------------------------------------------
module tb_sp_multicycle;

  localparam int MEM_AW = 12;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  sp_multicycle_if #(.MEM_AW(MEM_AW)) bus ();

  sp_multicycle #(.MEM_AW(MEM_AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Counters and check
  // ---------------------------------------------------------------------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int wen_cnt   = 0;
  logic [31:0] pc_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Data memory model
  // ---------------------------------------------------------------------------
  logic [31:0] mem_model [0:(1<<MEM_AW)-1];

  always @(posedge clk) begin
    if (bus.mem_wen) mem_model[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem_model[bus.mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Write scoreboard: each observed write cycle pops one expected {addr,data}
  // ---------------------------------------------------------------------------
  logic [MEM_AW+31:0] exp_q [$];

  always @(negedge clk) begin
    if (bus.mem_wen) begin
      logic [MEM_AW+31:0] e;
      wen_cnt++;
      check("wr_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", {{(32-MEM_AW){1'b0}}, bus.mem_addr}, {{(32-MEM_AW){1'b0}}, e[MEM_AW+31:32]});
        check("wr_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Encoders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic run(input logic [31:0] ins, input int exp_lat, input logic [31:0] exp_pc,
                     input string tag, input bit hold = 1'b0, input logic [31:0] junk = 32'd0);
    int lat;
    bus.in_valid = 1'b1;
    bus.inst     = ins;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (hold) bus.inst = junk;   // in_valid stays high into EXEC
    else      bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 8) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_pc"}, bus.inst_addr, exp_pc);
    @(negedge clk);
    check({tag, "_ov_pulse"}, {31'd0, bus.out_valid}, 32'd0);
    pc_m = exp_pc;
  endtask

  task automatic step(input logic [31:0] ins, input string tag);
    run(ins, (ins[31:26] == 6'd5) ? 3 : 2, pc_m + 32'd4, tag);
  endtask

  task automatic sw_expect(input logic [4:0] rt, input logic [MEM_AW-1:0] a, input logic [31:0] v);
    exp_q.push_back({a, v});
    step(enc_i(6'd6, 5'd0, rt, {{(16-MEM_AW){1'b0}}, a}), "sw");
  endtask

  task automatic read_reg(input logic [4:0] r, input logic [31:0] v);
    sw_expect(r, MEM_AW'(200 + int'(r)), v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_inst_addr", bus.inst_addr, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    pc_m = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int wen0;

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.inst     = 32'd0;
    pc_m         = 32'd0;
    #1;
    check("rst_out_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_inst_addr",  bus.inst_addr, 32'd0);
    check("rst_mem_wen",    {31'd0, bus.mem_wen}, 32'd0);
    check("rst_mem_addr",   {20'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata",  bus.mem_wdata, 32'd0);
    check("rst_state",      {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Every register reads back as zero after reset
    for (int i = 0; i < 32; i++) read_reg(5'(i), 32'd0);

    // addi / ori with pc 4 then 8
    do_reset();
    run(32'h0C01FFFB, 2, 32'd4, "addi_neg");
    run(enc_i(6'd2, 5'd0, 5'd2, 16'hFFFB), 2, 32'd8, "ori");
    read_reg(5'd1, 32'hFFFF_FFFB);
    read_reg(5'd2, 32'h0000_FFFB);

    // slt (signed) both directions, sll
    step(enc_i(6'd3, 5'd0, 5'd2, 16'd3), "addi_r2");
    step(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'd4), "slt");
    step(enc_r(5'd2, 5'd1, 5'd6, 5'd0, 6'd4), "slt_rev");
    read_reg(5'd3, 32'd1);
    read_reg(5'd6, 32'd0);
    step(enc_i(6'd3, 5'd0, 5'd1, 16'd1), "addi_r1");
    step(enc_r(5'd1, 5'd0, 5'd4, 5'd4, 6'd5), "sll");
    read_reg(5'd4, 32'd16);

    // Remaining ALU ops (r1=1, r2=3, r4=16)
    step(enc_r(5'd1, 5'd2, 5'd7,  5'd0, 6'd2), "add");
    step(enc_r(5'd1, 5'd2, 5'd8,  5'd0, 6'd3), "sub");
    step(enc_r(5'd0, 5'd0, 5'd9,  5'd0, 6'd6), "nor");
    step(enc_r(5'd9, 5'd2, 5'd10, 5'd0, 6'd0), "and");
    step(enc_r(5'd1, 5'd4, 5'd11, 5'd0, 6'd1), "or");
    step(enc_i(6'd4, 5'd2, 5'd12, 16'd1),      "subi");
    step(enc_i(6'd1, 5'd9, 5'd13, 16'h8001),   "andi");
    step(enc_i(6'd9, 5'd0, 5'd14, 16'h1234),   "lui");
    step(enc_i(6'd63, 5'd0, 5'd15, 16'd1),     "bad_op");
    step(enc_r(5'd9, 5'd9, 5'd16, 5'd0, 6'd63), "bad_func");
    read_reg(5'd7,  32'd4);
    read_reg(5'd8,  32'hFFFF_FFFE);
    read_reg(5'd9,  32'hFFFF_FFFF);
    read_reg(5'd10, 32'd3);
    read_reg(5'd11, 32'd17);
    read_reg(5'd12, 32'd2);
    read_reg(5'd13, 32'h0000_8001);
    read_reg(5'd14, 32'h1234_0000);
    read_reg(5'd15, 32'd0);
    read_reg(5'd16, 32'd0);

    // in_valid held into EXEC with another instruction: must be ignored
    run(enc_i(6'd3, 5'd0, 5'd17, 16'd5), 2, pc_m + 32'd4, "hold", 1'b1,
        enc_i(6'd3, 5'd0, 5'd1, 16'd100));
    read_reg(5'd17, 32'd5);
    read_reg(5'd1,  32'd1);

    // sw r2 -> word 10, then lw r5 <- word 10
    wen0 = wen_cnt;
    sw_expect(5'd2, 12'd10, 32'd3);
    check("sw_wen_cycles", wen_cnt - wen0, 32'd1);
    wen0 = wen_cnt;
    step(enc_i(6'd5, 5'd0, 5'd5, 16'd10), "lw");
    check("lw_wen_cycles", wen_cnt - wen0, 32'd0);
    read_reg(5'd5, 32'd3);
    // Negative offset wraps within the word-address space: 1 + (-2) -> 0xFFF
    sw_expect(5'd4, 12'hFFF, 32'd16);
    exp_q.push_back({12'hFFF, 32'd16});
    step(enc_i(6'd6, 5'd1, 5'd4, 16'hFFFE), "sw_wrap");

    // Control flow
    do_reset();
    step(enc_i(6'd3, 5'd0, 5'd1, 16'd7), "addi_b1");
    step(enc_i(6'd3, 5'd0, 5'd2, 16'd7), "addi_b2");
    run(enc_i(6'd7, 5'd1, 5'd2, 16'hFFFE), 2, 32'd4,     "beq_t");
    run(enc_j(6'd11, 26'h40),              2, 32'h100,   "jal");
    run(enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'd7), 2, 32'd8,  "jr");
    run(enc_i(6'd8, 5'd1, 5'd2, 16'hFFFE), 2, 32'd12,    "bne_nt");
    run(enc_i(6'd7, 5'd1, 5'd0, 16'd4),    2, 32'd16,    "beq_nt");
    run(enc_i(6'd8, 5'd1, 5'd0, 16'd4),    2, 32'd36,    "bne_t");
    run(enc_j(6'd10, 26'h10),              2, 32'h40,    "j");
    read_reg(5'd31, 32'd8);

    // Reset during EXEC of a store aborts it
    bus.in_valid = 1'b1;
    bus.inst     = enc_i(6'd6, 5'd0, 5'd2, 16'd30);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    check("abort_wen_exec", {31'd0, bus.mem_wen}, 32'd1);
    wen0 = wen_cnt;
    rst  = 1'b1;
    #1;
    check("abort_wen",       {31'd0, bus.mem_wen}, 32'd0);
    check("abort_inst_addr", bus.inst_addr, 32'd0);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_state",     {30'd0, dbg_state}, 32'd0);
    check("abort_mem_addr",  {20'd0, bus.mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    check("abort_no_write", wen_cnt - wen0, 32'd0);
    rst  = 1'b0;
    pc_m = 32'd0;
    // Accepted on the first rising edge after reset release
    step(enc_i(6'd3, 5'd0, 5'd1, 16'd9), "post_rst");
    read_reg(5'd1, 32'd9);
    read_reg(5'd2, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard ceiling in case a handshake never completes
  initial begin
    #500000;
    $display("FAIL timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sp_multicycle.md
SP_MULTICYCLE -- requirements
Module: sp_multicycle

Interface
REQ-001 SHALL have parameter MEM_AW, default 12, data-memory word-address width (4096 words).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  inst is valid this cycle; one-cycle pulse.
REQ-005 SHALL have port inst  input  32  instruction word; only meaningful while in_valid=1.
REQ-006 SHALL have port out_valid  output  1  one-cycle pulse marking instruction retirement.
REQ-007 SHALL have port inst_addr  output  32  byte address of the next instruction to fetch.
REQ-008 SHALL have port mem_addr  output  MEM_AW  data-memory word address.
REQ-009 SHALL have port mem_wen  output  1  data-memory write enable, active high.
REQ-010 SHALL have port mem_wdata  output  32  data-memory write data.
REQ-011 SHALL have port mem_rdata  input  32  read data, valid one cycle after mem_addr is presented.
REQ-012 SHALL hold register file r[0..31], 32 bits each; r[0] is ordinary and writable.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> (MEMRD, lw only) -> DONE -> IDLE.
REQ-014 SHALL latch inst in IDLE when in_valid=1 and move to EXEC on the next edge; in_valid outside IDLE SHALL be ignored.
REQ-015 SHALL decode: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], func=[5:0], imm=[15:0], addr=[25:0].
REQ-016 SHALL, for opcode 0, execute func 0 and, 1 or, 2 add, 3 sub, 4 slt (signed; rd=1 or 0), 5 sll (rd=r[rs]<<shamt), 6 nor, 7 jr (pc=r[rs]); writes go to r[rd].
REQ-017 SHALL execute andi(1) and ori(2) with zero-extended imm, and addi(3), subi(4) with sign-extended imm; writes go to r[rt].
REQ-018 SHALL execute lui(9) as r[rt]={imm,16'h0}.
REQ-019 SHALL compute lw(5)/sw(6) word address r[rs]+sext(imm), truncated to MEM_AW bits.
REQ-020 SHALL, for sw, drive mem_addr, mem_wdata=r[rt] and mem_wen=1 during EXEC only.
REQ-021 SHALL, for lw, drive mem_addr in EXEC, then write mem_rdata to r[rt] in MEMRD.
REQ-022 SHALL compute next pc as follows: beq(7) taken if r[rs]==r[rt], bne(8) taken if r[rs]!=r[rt]; taken target = pc+4+(sext(imm)<<2).
REQ-023 SHALL compute j(10)/jal(11) target as {pc[31:28], addr, 2'b00}; jal also writes r[31]=pc+4.
REQ-024 SHALL, for all other cases, set next pc = pc+4; 32-bit arithmetic wraps modulo 2^32.
REQ-025 SHALL treat undefined opcode/func as a no-op: no register or memory write, pc+4.
REQ-026 SHALL update the register write and inst_addr on the edge entering DONE, so both are stable while out_valid=1.
REQ-027 SHALL assert out_valid only in DONE: 2 cycles after the in_valid cycle for non-lw, 3 cycles for lw; never two consecutive cycles.
REQ-028 SHALL hold mem_wen=0 in all states other than EXEC-with-sw.

Reset
REQ-029 SHALL, on rst=1 and independent of clk, force state=IDLE, out_valid=0, inst_addr=0, mem_wen=0, mem_addr=0, mem_wdata=0, and all r[i]=0.
REQ-030 SHALL abort any in-flight instruction on reset mid-operation, with no register or memory write after rst rises.
REQ-031 SHALL accept a new in_valid on the first rising edge after rst falls.

Verification
REQ-032 SHALL pass this check: reset pulse -> out_valid=0, inst_addr=0, all r=0.
REQ-033 SHALL pass this check: addi r1,r0,-5 (0x0C01FFFB), then ori r2,r0,0xFFFB -> r1=0xFFFFFFFB, r2=0x0000FFFB, inst_addr 4 then 8, out_valid 2 cycles after each in_valid.
REQ-034 SHALL pass this check: slt r3,r1,r2 with r1=-5, r2=3 -> r3=1; sll r4,r1,shamt 4 with r1=1 -> r4=16.
REQ-035 SHALL pass this check: sw r2 to r0+10, then lw r5 from r0+10 -> mem_wen high for exactly one cycle at addr 10, r5=r2, lw out_valid 3 cycles after in_valid.
REQ-036 SHALL pass this check: at pc=8, beq with r1==r2 and imm=-2 -> inst_addr=4; jal with addr=0x40 at pc=4 -> r31=8, inst_addr=0x100; jr r31 -> inst_addr=8.
REQ-037 SHALL pass this check: rst asserted during EXEC of sw -> mem_wen=0 immediately, no memory write, inst_addr=0.
